// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ID instruction into ALU/branch controls, registers
// operands for EX, and raises a combinational load-use stall toward IF/ID.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            stall,
  input  logic            flush,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [9:0]      ex_alu_ctrl,
  output logic [2:0]      ex_bropcode,
  output logic            ex_alusrc_imm,
  output logic            ex_is_branch,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [9:0]      alu_ctrl;
    logic [2:0]      bropcode;
    logic            alusrc_imm;
    logic            is_branch;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            illegal;
  } ex_t;

  ex_t ex_d, ex_q, dec;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       rs1_used, rs2_used, rs2_zero, dec_reg_write;
  logic       unused_instr;

  assign opcode       = id_instr[6:0];
  assign funct3       = id_instr[14:12];
  assign funct7b5     = id_instr[30];
  assign unused_instr = ^{id_instr[31], id_instr[29:25]};

  function automatic logic [9:0] alu_sel(input logic [2:0] f3, input logic alt);
    logic [9:0] sel;
    sel = '0;
    case (f3)
      3'b000:  sel[alt ? 1 : 0] = 1'b1;
      3'b001:  sel[2] = 1'b1;
      3'b010:  sel[3] = 1'b1;
      3'b011:  sel[4] = 1'b1;
      3'b100:  sel[5] = 1'b1;
      3'b101:  sel[alt ? 7 : 6] = 1'b1;
      3'b110:  sel[8] = 1'b1;
      default: sel[9] = 1'b1;
    endcase
    return sel;
  endfunction

  always_comb begin
    dec           = '0;
    rs1_used      = 1'b0;
    rs2_used      = 1'b0;
    rs2_zero      = 1'b0;
    dec_reg_write = 1'b0;
    dec.valid     = 1'b1;
    dec.pc        = id_pc;
    dec.rs1_data  = id_rs1_data;
    dec.rs2_data  = id_rs2_data;
    dec.imm       = id_imm;
    unique case (opcode)
      OpR: begin
        dec.alu_ctrl  = alu_sel(funct3, funct7b5);
        dec_reg_write = 1'b1;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OpImm: begin
        // funct7b5 only selects SRA; for ADDI it is an immediate bit
        dec.alu_ctrl   = alu_sel(funct3, (funct3 == 3'b101) && funct7b5);
        dec.alusrc_imm = 1'b1;
        dec_reg_write  = 1'b1;
        rs1_used       = 1'b1;
        rs2_zero       = 1'b1;
      end
      OpLoad: begin
        dec.alu_ctrl   = 10'b1;
        dec.alusrc_imm = 1'b1;
        dec.mem_read   = 1'b1;
        dec_reg_write  = 1'b1;
        rs1_used       = 1'b1;
        rs2_zero       = 1'b1;
      end
      OpStore: begin
        dec.alu_ctrl   = 10'b1;
        dec.alusrc_imm = 1'b1;
        dec.mem_write  = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OpBranch: begin
        if (funct3[2:1] == 2'b01) begin
          dec.illegal = 1'b1;
        end else begin
          dec.is_branch = 1'b1;
          dec.bropcode  = funct3;
          rs1_used      = 1'b1;
          rs2_used      = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // Writes to x0 are dropped here so EX/WB never see a live x0 destination
    dec.reg_write = dec_reg_write && (id_instr[11:7] != 5'd0);
    dec.rd        = dec.reg_write ? id_instr[11:7] : 5'd0;
    dec.rs1       = id_instr[19:15];
    dec.rs2       = rs2_zero ? 5'd0 : id_instr[24:20];
  end

  assign hazard_stall = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                        (((ex_q.rd == dec.rs1) && rs1_used) ||
                         ((ex_q.rd == dec.rs2) && rs2_used));

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (hazard_stall || !id_valid) begin
      ex_d = '0;
    end else begin
      ex_d = dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_alu_ctrl   = ex_q.alu_ctrl;
  assign ex_bropcode   = ex_q.bropcode;
  assign ex_alusrc_imm = ex_q.alusrc_imm;
  assign ex_is_branch  = ex_q.is_branch;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: decode vector table through a scoreboard queue, then
// hand sequences for load-use, stall/flush priority and asynchronous reset.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  localparam logic [5:0] FAluSrc = 6'b100000;
  localparam logic [5:0] FBr     = 6'b010000;
  localparam logic [5:0] FMr     = 6'b001000;
  localparam logic [5:0] FMw     = 6'b000100;
  localparam logic [5:0] FRw     = 6'b000010;
  localparam logic [5:0] FIll    = 6'b000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, id_valid, stall, flush, hazard_stall, ex_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [9:0]      ex_alu_ctrl;
  logic [2:0]      ex_bropcode;
  logic ex_alusrc_imm, ex_is_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .stall(stall), .flush(flush), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_bropcode(ex_bropcode), .ex_alusrc_imm(ex_alusrc_imm), .ex_is_branch(ex_is_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [9:0]      alu;
    logic [2:0]      bropc;
    logic [5:0]      flags;
  } obs_t;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [9:0]  alu;
    logic [2:0]  bropc;
    logic [5:0]  flags;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  vec_t vecs[$];
  obs_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic obs_t observed();
    return '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_alu_ctrl, ex_bropcode,
             {ex_alusrc_imm, ex_is_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal}};
  endfunction

  // Expected EX contents for the instruction currently driven on the ID inputs
  function automatic obs_t expect_id(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [9:0] alu,
                                     input logic [2:0] bropc, input logic [5:0] flags);
    return '{1'b1, id_pc, id_rs1_data, id_rs2_data, id_imm, rs1, rs2, rd, alu, bropc, flags};
  endfunction

  task automatic check(input string nm, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic check1(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    id_valid    = v;
    id_instr    = ins;
    id_pc       = $urandom;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_imm      = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  obs_t exp_v, held;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0000_0013);
    // {valid, instr, alu, bropc, flags, rd, rs1, rs2}
    vecs.push_back('{1'b1, 32'h40208033, 10'h002, 3'd0, 6'd0,          5'd0,  5'd1,  5'd2});
    vecs.push_back('{1'b1, 32'h4020D093, 10'h080, 3'd0, FAluSrc | FRw, 5'd1,  5'd1,  5'd0});
    vecs.push_back('{1'b1, 32'h0020F0B3, 10'h200, 3'd0, FRw,           5'd1,  5'd1,  5'd2});
    vecs.push_back('{1'b1, 32'h00209463, 10'h000, 3'd1, FBr,           5'd0,  5'd1,  5'd2});
    vecs.push_back('{1'b1, 32'hFFFFFFFF, 10'h000, 3'd0, FIll,          5'd0,  5'd31, 5'd31});
    vecs.push_back('{1'b1, 32'h00728333, 10'h001, 3'd0, FRw,           5'd6,  5'd5,  5'd7});
    vecs.push_back('{1'b1, 32'h405201B3, 10'h002, 3'd0, FRw,           5'd3,  5'd4,  5'd5});
    vecs.push_back('{1'b1, 32'h40018113, 10'h001, 3'd0, FAluSrc | FRw, 5'd2,  5'd3,  5'd0});
    vecs.push_back('{1'b1, 32'h00125213, 10'h040, 3'd0, FAluSrc | FRw, 5'd4,  5'd4,  5'd0});
    vecs.push_back('{1'b1, 32'h00434293, 10'h020, 3'd0, FAluSrc | FRw, 5'd5,  5'd6,  5'd0});
    vecs.push_back('{1'b1, 32'h0020A423, 10'h001, 3'd0, FAluSrc | FMw, 5'd0,  5'd1,  5'd2});
    vecs.push_back('{1'b1, 32'h009433B3, 10'h010, 3'd0, FRw,           5'd7,  5'd8,  5'd9});
    vecs.push_back('{1'b1, 32'h0020A463, 10'h000, 3'd0, FIll,          5'd0,  5'd1,  5'd2});
    vecs.push_back('{1'b1, 32'h0005A503, 10'h001, 3'd0, FAluSrc | FMr | FRw, 5'd10, 5'd11, 5'd0});
    vecs.push_back('{1'b1, 32'h0041F063, 10'h000, 3'd7, FBr,           5'd0,  5'd3,  5'd4});
    vecs.push_back('{1'b1, 32'h003160B3, 10'h100, 3'd0, FRw,           5'd1,  5'd2,  5'd3});
    vecs.push_back('{1'b1, 32'h003120B3, 10'h008, 3'd0, FRw,           5'd1,  5'd2,  5'd3});
    vecs.push_back('{1'b1, 32'h003110B3, 10'h004, 3'd0, FRw,           5'd1,  5'd2,  5'd3});
    vecs.push_back('{1'b1, 32'h403150B3, 10'h080, 3'd0, FRw,           5'd1,  5'd2,  5'd3});
    vecs.push_back('{1'b1, 32'h003150B3, 10'h040, 3'd0, FRw,           5'd1,  5'd2,  5'd3});
    vecs.push_back('{1'b0, 32'h00728333, 10'h000, 3'd0, 6'd0,          5'd0,  5'd0,  5'd0});

    #12;
    check("reset_state", observed(), '0);
    check1("reset_hazard", hazard_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Decode table through the scoreboard
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].instr);
      if (vecs[i].valid) begin
        sb_q.push_back(expect_id(vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].alu,
                                 vecs[i].bropc, vecs[i].flags));
      end else begin
        sb_q.push_back('0);
      end
      #1;
      check1($sformatf("vec%0d_hazard", i), hazard_stall, 1'b0);
      tick();
      check($sformatf("vec%0d", i), observed(), sb_q.pop_front());
    end

    // Load-use: exactly one bubble, then the dependent add
    drive(1'b1, 32'h0000A283);
    exp_v = expect_id(5'd5, 5'd1, 5'd0, 10'h001, 3'd0, FAluSrc | FMr | FRw);
    tick();
    check("lu_load", observed(), exp_v);
    drive(1'b1, 32'h00728333);
    exp_v = expect_id(5'd6, 5'd5, 5'd7, 10'h001, 3'd0, FRw);
    #1;
    check1("lu_hazard", hazard_stall, 1'b1);
    tick();
    check("lu_bubble", observed(), '0);
    check1("lu_hazard_clear", hazard_stall, 1'b0);
    tick();
    check("lu_add", observed(), exp_v);

    // Stall together with a load-use hazard holds EX and keeps hazard_stall up
    drive(1'b1, 32'h0000A283);
    held = expect_id(5'd5, 5'd1, 5'd0, 10'h001, 3'd0, FAluSrc | FMr | FRw);
    tick();
    drive(1'b1, 32'h00728333);
    exp_v = expect_id(5'd6, 5'd5, 5'd7, 10'h001, 3'd0, FRw);
    stall = 1'b1;
    #1;
    check1("sh_hazard", hazard_stall, 1'b1);
    tick();
    check("sh_hold", observed(), held);
    check1("sh_hazard_held", hazard_stall, 1'b1);
    stall = 1'b0;
    tick();
    check("sh_bubble", observed(), '0);
    tick();
    check("sh_add", observed(), exp_v);

    // Load to x0 never stalls
    drive(1'b1, 32'h0000A003);
    tick();
    drive(1'b1, 32'h00700333);
    exp_v = expect_id(5'd6, 5'd0, 5'd7, 10'h001, 3'd0, FRw);
    #1;
    check1("x0_hazard", hazard_stall, 1'b0);
    tick();
    check("x0_add", observed(), exp_v);

    // stall alone holds for three cycles, then flush beats stall
    drive(1'b1, 32'h0020A423);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall_hold%0d", c), observed(), exp_v);
    end
    flush = 1'b1;
    tick();
    check("flush_over_stall", observed(), '0);
    flush = 1'b0;
    stall = 1'b0;

    // Asynchronous reset mid-cycle, then normal load after release
    drive(1'b1, 32'h0020F0B3);
    exp_v = expect_id(5'd1, 5'd1, 5'd2, 10'h200, 3'd0, FRw);
    tick();
    check("pre_reset", observed(), exp_v);
    #1 rst = 1'b1;
    #1;
    check("async_reset", observed(), '0);
    #1 rst = 1'b0;
    tick();
    check("post_reset", observed(), exp_v);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
